uart_tx_buffered: RTL

//   Buffered UART transmitter: accepts bytes on a valid/ready stream into an internal FIFO and

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_buffered.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, transmitter state encoding and baud-divider helper.
package uart_pkg;

    localparam int OSF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int clk_div_count(input int clk_freq, input int baud);
        return clk_freq / (OSF * baud);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO for the UART transmitter, show-ahead read data.
// Latency: a write is visible on rd_data/level the cycle after it is accepted.
// Backpressure: writes while full and reads while empty are ignored.
module uart_tx_fifo
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter, 8N1 LSB first; define UART_TX_PARITY_EN for 8E1/8O1 framing.
// Latency: a byte written to an empty FIFO while idle starts its start bit two clocks later.
// Backpressure: wr_ready is low while DEPTH bytes are queued; writes then are dropped.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DEPTH      = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int DIV    = clk_div_count(CLK_FREQ, BAUD);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OSF);

    tx_state_t         state_q, state_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic              stop_q, stop_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              pop;
    logic              tick;
    logic              bit_done;
    logic              stop_last;
    logic [7:0]        fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_full;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`else
    logic              unused_parity_odd;
    assign unused_parity_odd = 1'(PARITY_ODD);
`endif

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (level)
    );

    assign wr_ready  = !fifo_full;
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;
    assign tick      = (presc_q == DIV_W'(DIV - 1));
    assign bit_done  = tick && (tick_q == TICK_W'(OSF - 1));
    assign stop_last = (stop_q == 1'(STOP_BITS - 1));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            presc_d = tick ? '0 : presc_q + DIV_W'(1);
            if (tick) tick_d = tick_q + TICK_W'(1);
        end

        case (state_q)
            IDLE: begin
                // Timing restarts on load so every bit is exactly OSF*DIV clocks.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    presc_d = '0;
                    tick_d  = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    shift_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^fifo_rd_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (stop_last) state_d = IDLE;
                    else           stop_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from next-state values to keep tx glitch-free.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
